// File: rtl/da_engine_param.sv
// Parametrised distributed-arithmetic FIR engine: NBANK loadable LUTs, a pipelined adder tree, and an MSB-first accumulator.
// Optional build macro DA_SIGNED_EN: treat samples as two's complement (first slice weighted negative).
module da_engine_param #(
  parameter  int NBANK = 8,
  parameter  int AW    = 8,
  parameter  int CW    = 20,
  parameter  int BW    = 16,
  localparam int L     = $clog2(NBANK),
  localparam int ACCW  = CW + L + BW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cload,
  input  logic [L+AW-1:0]         caddr,
  input  logic signed [CW-1:0]    cin,
  output logic                    cload_err,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NBANK*AW-1:0]     slice_addr,
  output logic signed [ACCW-1:0]  acc_out,
  output logic                    out_valid
);

  localparam int TW    = CW + L;
  localparam int CNTW  = $clog2(BW);
  localparam int DEPTH = NBANK * (2 ** AW);
  localparam int NNODE = 2 * NBANK - 1;

  logic signed [CW-1:0]   r_lut [DEPTH];
  logic signed [TW-1:0]   r_node [NNODE];
  logic signed [CW-1:0]   w_rd [NBANK];

  logic [CNTW-1:0]        r_cnt;
  logic [L:0]             r_v;
  logic [L:0]             r_first;
  logic [L:0]             r_last;
  logic                   r_va;
  logic signed [ACCW-1:0] r_acc;
  logic signed [ACCW-1:0] r_acc_out;
  logic                   r_out_valid;
  logic                   r_cload_err;

  logic                   w_accept;
  logic                   w_idle;
  logic                   w_cnt_wrap;
  logic signed [ACCW-1:0] w_sum_ext;
  logic signed [ACCW-1:0] w_acc_next;

  assign in_ready   = !cload;
  assign w_accept   = in_valid && !cload;
  assign w_cnt_wrap = (r_cnt == CNTW'(BW - 1));
  // Writes are only safe with no slice anywhere in flight, so a word never mixes old and new coefficients.
  assign w_idle     = (r_cnt == '0) && !(|r_v) && !r_va;

  always_ff @(posedge clk) begin
    if (cload && w_idle) begin
      r_lut[caddr] <= cin;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NBANK; gi++) begin : g_bank
      assign w_rd[gi] = r_lut[{L'(gi), slice_addr[gi*AW +: AW]}];
    end
  endgenerate

  // Heap-ordered tree: leaves at NBANK-1.., root at 0; every leaf sits L stages from the root.
  // All nodes are TW wide; a level-k node only ever holds values that fit CW+k bits.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBANK - 1; i++) begin
      r_node[i] <= r_node[2*i+1] + r_node[2*i+2];
    end
    for (int b = 0; b < NBANK; b++) begin
      r_node[NBANK-1+b] <= {{L{w_rd[b][CW-1]}}, w_rd[b]};
    end
  end

  assign w_sum_ext = {{BW{r_node[0][TW-1]}}, r_node[0]};

  always_comb begin
    w_acc_next = (r_acc <<< 1) + w_sum_ext;
    if (r_first[L]) begin
`ifdef DA_SIGNED_EN
      w_acc_next = -w_sum_ext;
`else
      w_acc_next = w_sum_ext;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_v         <= '0;
      r_first     <= '0;
      r_last      <= '0;
      r_va        <= 1'b0;
      r_acc       <= '0;
      r_acc_out   <= '0;
      r_out_valid <= 1'b0;
      r_cload_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
      end
      r_v         <= {r_v[L-1:0], w_accept};
      r_first     <= {r_first[L-1:0], w_accept && (r_cnt == '0)};
      r_last      <= {r_last[L-1:0], w_accept && w_cnt_wrap};
      r_va        <= r_v[L];
      if (r_v[L]) begin
        r_acc <= w_acc_next;
      end
      r_out_valid <= r_v[L] && r_last[L];
      if (r_v[L] && r_last[L]) begin
        r_acc_out <= w_acc_next;
      end
      r_cload_err <= cload && !w_idle;
    end
  end

  assign acc_out   = r_acc_out;
  assign out_valid = r_out_valid;
  assign cload_err = r_cload_err;

endmodule

// File: tb/tb_da_engine_param.sv
// Bench for da_engine_param: a per-word arithmetic reference model checked every cycle, plus literal pins.
module tb_da_engine_param;
  localparam int NBANK = 4;
  localparam int AW    = 4;
  localparam int CW    = 16;
  localparam int BW    = 8;
  localparam int L     = 2;
  localparam int ACCW  = CW + L + BW;
`ifdef DA_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   cload;
  logic [L+AW-1:0]        caddr;
  logic signed [CW-1:0]   cin;
  logic                   cload_err;
  logic                   in_valid;
  logic                   in_ready;
  logic [NBANK*AW-1:0]    slice_addr;
  logic signed [ACCW-1:0] acc_out;
  logic                   out_valid;

  da_engine_param #(.NBANK(NBANK), .AW(AW), .CW(CW), .BW(BW)) dut (
    .clk(clk), .reset(reset), .cload(cload), .caddr(caddr), .cin(cin),
    .cload_err(cload_err), .in_valid(in_valid), .in_ready(in_ready),
    .slice_addr(slice_addr), .acc_out(acc_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each word is sum_j weight(j) * (sum of the banks' LUT entries for slice j).
  typedef struct {longint val; int due;} exp_t;
  exp_t   q[$];
  longint mlut[NBANK * (1 << AW)];
  int     mcnt = 0;
  longint part = 0;
  longint s_tmp;
  int     ecount = 0;
  int     last_acc = -100;
  int     err_edge = -100;
  longint exp_acc = 0;
  bit     exp_ov;
  int     n_out = 0;
  int     n_err_pulse = 0;
  longint last_out = 0;
  int     out_edges[$];

  function automatic longint weight(input int j);
    longint w;
    w = longint'(1) <<< (BW - 1 - j);
    if (SGN && j == 0) w = -w;
    return w;
  endfunction

  always @(posedge clk) begin
    ecount++;
    if (!reset) begin
      if (cload) begin
        if (mcnt == 0 && (ecount - last_acc) > L + 2) mlut[caddr] = cin;
        else err_edge = ecount;
      end else if (in_valid) begin
        s_tmp = 0;
        for (int b = 0; b < NBANK; b++) s_tmp += mlut[b * (1 << AW) + int'(slice_addr[b*AW +: AW])];
        part += weight(mcnt) * s_tmp;
        if (mcnt == BW - 1) begin
          q.push_back('{part, ecount + L + 1});
          part = 0;
        end
        mcnt = (mcnt + 1) % BW;
        last_acc = ecount;
      end
    end
  end

  always @(posedge reset) begin
    mcnt = 0;
    part = 0;
    q.delete();
    exp_acc = 0;
    last_acc = -100;
    err_edge = -100;
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_acc_out", acc_out, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_cload_err", cload_err, 0);
    end else begin
      while (q.size() > 0 && q[0].due < ecount) begin
        chk("late_out", ecount, q[0].due);
        void'(q.pop_front());
      end
      exp_ov = (q.size() > 0 && q[0].due == ecount);
      if (exp_ov) begin
        exp_acc = q[0].val;
        void'(q.pop_front());
      end
      chk("out_valid", out_valid, exp_ov);
      chk("acc_out", acc_out, exp_acc);
      chk("cload_err", cload_err, err_edge == ecount);
      chk("in_ready", in_ready, !cload);
      if (out_valid) begin
        n_out++;
        last_out = acc_out;
        out_edges.push_back(ecount);
      end
      if (cload_err) n_err_pulse++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input longint d);
    cload = 1'b1;
    caddr = 6'(a);
    cin   = 16'(d);
    tick();
    cload = 1'b0;
  endtask

  task automatic slice(input logic [15:0] sa);
    in_valid   = 1'b1;
    slice_addr = sa;
    tick();
  endtask

  task automatic word(input logic [15:0] sa);
    for (int j = 0; j < BW; j++) slice(sa);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input longint exp);
    int n0;
    int k;
    n0 = n_out;
    k = 0;
    while (n_out == n0 && k < 40) begin
      tick();
      k++;
    end
    if (n_out == n0) chk({name, "_timeout"}, n_out - n0, 1);
    else chk(name, last_out, exp);
    $display("word %s: acc_out=%0d expected=%0d", name, last_out, exp);
  endtask

  int t_last;
  int e0;

  initial begin
    reset = 1'b1; cload = 1'b0; in_valid = 1'b0; caddr = '0; cin = '0; slice_addr = '0;
    for (int i = 0; i < NBANK * (1 << AW); i++) mlut[i] = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    tick();
    chk("reset_acc_out", acc_out, 0);
    chk("reset_out_valid", out_valid, 0);

    // Test 1: single tap
    for (int a = 0; a < NBANK * (1 << AW); a++) wr(a, 0);
    wr(1, 5);
    word(16'h0001);
    wait_out("t1", SGN ? -5 : 1275);

    // Test 2: three back-to-back words
    repeat (3) tick();
    out_edges.delete();
    for (int j = 0; j < 3 * BW; j++) slice(16'h0001);
    t_last = ecount;
    in_valid = 1'b0;
    repeat (8) tick();
    chk("t2_count", out_edges.size(), 3);
    if (out_edges.size() == 3) begin
      chk("t2_gap1", out_edges[1] - out_edges[0], 8);
      chk("t2_gap2", out_edges[2] - out_edges[1], 8);
      chk("t2_latency", out_edges[2] - t_last, 3);
    end
    chk("t2_value", last_out, SGN ? -5 : 1275);

    // Test 3: write rejected mid-word
    repeat (3) tick();
    e0 = n_err_pulse;
    for (int j = 0; j < 3; j++) slice(16'h0001);
    cload = 1'b1; caddr = 6'h01; cin = 16'sd7; in_valid = 1'b1;
    tick();
    cload = 1'b0;
    for (int j = 0; j < 5; j++) slice(16'h0001);
    in_valid = 1'b0;
    wait_out("t3", SGN ? -5 : 1275);
    chk("t3_err_pulses", n_err_pulse - e0, 1);
    repeat (3) tick();
    wr(1, 7);
    word(16'h0001);
    wait_out("t3b", SGN ? -7 : 1785);

    // Test 4: full-scale negative entries in every bank
    repeat (3) tick();
    for (int b = 0; b < NBANK; b++) wr(b * 16 + 15, -32768);
    word(16'hFFFF);
    wait_out("t4", SGN ? 131072 : -33423360);

    // Test 5: asynchronous reset mid-word
    repeat (3) tick();
    for (int j = 0; j < 5; j++) slice(16'hFFFF);
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("t5_acc_async", acc_out, 0);
    chk("t5_ov_async", out_valid, 0);
    tick();
    tick();
    #3 reset = 1'b0;
    tick();
    word(16'hFFFF);
    wait_out("t5", SGN ? 131072 : -33423360);

    // Test 6: write and slice collide in an idle cycle
    repeat (4) tick();
    cload = 1'b1; caddr = 6'h01; cin = 16'sd9; in_valid = 1'b1; slice_addr = 16'h0001;
    tick();
    cload = 1'b0;
    word(16'h0001);
    wait_out("t6", SGN ? -9 : 2295);

    // Randomized traffic, with idle windows so some writes land
    for (int p = 0; p < 8; p++) begin
      cload = 1'b0; in_valid = 1'b0;
      repeat (6) tick();
      repeat (3) wr(int'($urandom_range(0, 63)), longint'($signed(16'($urandom))));
      repeat (50) begin
        cload      = ($urandom_range(0, 9) == 0);
        caddr      = 6'($urandom);
        cin        = 16'($urandom);
        in_valid   = ($urandom_range(0, 3) != 0);
        slice_addr = 16'($urandom);
        tick();
      end
    end
    cload = 1'b0; in_valid = 1'b0;
    repeat (12) tick();
    chk("drain_queue", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
